restoring_divider: RTL and testbench
====================================

// Module: restoring_divider
// PURPOSE
//   Sequential unsigned shift-subtract (restoring) divider: the inverse of the shift-add
//   multiplier datapath. Computes quotient = dividend / divisor and remainder =
//   dividend % divisor at one bit per clock. Has its own control FSM and a start/done
//   handshake, so it drops into the arithmetic lab tops beside the multiplier.
// PARAMETERS
//   N   4   operand width in bits (dividend, divisor, quotient, remainder); N >= 2
// PORTS
//   clk           in   1   clock, rising edge
//   reset         in   1   reset, asynchronous, active-high
//   start         in   1   request; sampled only in IDLE or DONE
//   dividend      in   N   unsigned dividend; captured on the accepting edge
//   divisor       in   N   unsigned divisor; captured on the accepting edge
//   quotient      out  N   result quotient; valid while done=1, held until next accept
//   remainder     out  N   result remainder; valid while done=1, held until next accept
//   busy          out  1   1 while in CALC
//   done          out  1   1 while in DONE (results valid)
//   div_by_zero   out  1   1 with done when the captured divisor was 0
// BEHAVIOUR
//   - Reset: state=IDLE, counter=0, work regs A(N+1b)=0, Q=0, M=0; all outputs 0.
//     Reset mid-operation aborts immediately. No partial result is kept.
//   - FSM: IDLE, CALC, DONE. Register all outputs; no combinational path from start to outputs.
//     IDLE --start & divisor!=0--> CALC: A<=0, Q<=dividend, M<=divisor, cnt<=N.
//     IDLE --start & divisor==0--> DONE: Q<=all ones, A<=dividend, dbz<=1.
//     CALC: each edge shifts {A,Q} left 1. T = {A[N-1:0],Q[N-1]} - {1'b0,M} in N+1 bits.
//       If T[N]==0: A<=T and Q[0]<=1. Otherwise A<=shifted A (restore) and Q[0]<=0.
//       cnt<=cnt-1. When cnt==1 on this edge, go to DONE.
//     DONE: done=1. start with divisor!=0 --> CALC (same load as IDLE).
//       start with divisor==0 --> stay in DONE with new dbz result. No start --> stay in DONE.
//   - dbz is cleared on every accept with divisor!=0.
//   - Latency: the edge that accepts start is edge 0. done=1 after edge N for a normal
//     divide, and after edge 0 for divide-by-zero.
//   - start in CALC is ignored: no restart and no effect on operands.
//   - quotient=Q[N-1:0] and remainder=A[N-1:0] are driven continuously.
//     They are defined only while done=1.
//   - Invariant at DONE (divisor!=0): dividend == quotient*divisor + remainder,
//     and remainder < divisor.
//   - Width rule: the trial subtract is N+1 bits, so the shifted partial remainder never
//     overflows. Counter width is $clog2(N+1).
// STRUCTURE
//   - Shared package/header div_pkg: state encodings S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2.
//   - Sub-module div_datapath (A/Q/M registers, trial subtractor, shift/restore mux).
//     It is driven by load, step and zload strobes from the FSM in this top.
//   - Counter and FSM live in restoring_divider.
// TESTING (N=4)
//   1. 13/4: pulse start -> busy for 4 cycles; done after edge 4; q=3, r=1, dbz=0.
//   2. 15/1 -> q=15, r=0. 3/7 -> q=0, r=3. 0/5 -> q=0, r=0. 15/15 -> q=1, r=0.
//   3. 9/0 -> done after edge 0; q=4'hF, r=9, dbz=1, busy never asserted.
//   4. Start 13/4, assert reset at edge 2 -> all outputs 0 and IDLE at once.
//      Start 6/4 after release -> q=1, r=2.
//   5. Start 13/4, then re-pulse start with 8/2 during CALC -> ignored, q=3, r=1.
//      Start 8/2 while in DONE -> accepted, result q=4, r=0 after 4 more edges.
//   6. Exhaustive: all 256 (dividend, divisor) pairs back-to-back.
//      Check the invariant or dbz on every done, plus a reference-model compare.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encodings.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// Partial-remainder (A), quotient (Q) and divisor (M) registers with the trial subtractor.
// Driven by load / zload / step strobes from the control FSM in restoring_divider.
module div_datapath #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         zload,
  input  logic         step,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  // A is always below M after each restore, so its N+1th bit is never set and is not stored;
  // the shifted value and the trial subtract still carry the full N+1 bits.
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] m_q, m_d;
  logic [N:0]   shifted;
  logic [N:0]   trial;

  always_comb begin
    shifted = {a_q, q_q[N-1]};
    trial   = shifted - {1'b0, m_q};
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    if (load) begin
      a_d = '0;
      q_d = dividend;
      m_d = divisor;
    end else if (zload) begin
      a_d = dividend;
      q_d = '1;
      m_d = divisor;
    end else if (step) begin
      // A non-negative trial keeps the difference and shifts in a 1; otherwise restore
      if (!trial[N]) begin
        a_d = trial[N-1:0];
        q_d = {q_q[N-2:0], 1'b1};
      end else begin
        a_d = shifted[N-1:0];
        q_d = {q_q[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
    end
  end

  assign quotient  = q_q;
  assign remainder = a_q;

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock with start/done handshake.
// Holds the control FSM and bit counter; the arithmetic lives in div_datapath.
module restoring_divider
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CntW = $clog2(N + 1);

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q, done_q, dbz_q;
  logic            accept, load, zload, step;

  // A request is only honoured when not already calculating
  always_comb begin
    accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    load   = accept && (divisor != '0);
    zload  = accept && (divisor == '0);
    step   = (state_q == S_CALC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (load) begin
            state_q <= S_CALC;
            cnt_q   <= CntW'(N);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
          end else if (zload) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
        end
      endcase
    end
  end

  div_datapath #(.N(N)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .zload     (zload),
    .step      (step),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (N=4): vector table, corner sequences,
// exhaustive and random sweeps against an arithmetic reference model.
module tb_restoring_divider;

  localparam int N = 4;
  localparam int MaxWait = 20;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [N-1:0] dvd;
    logic [N-1:0] dsr;
    logic [N-1:0] expQ;
    logic [N-1:0] expR;
    logic         expDbz;
    int           expLat;
  } vector_t;

  vector_t vectors[6];

  restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: plain integer division, with the divide-by-zero convention
  task automatic refModel(input logic [N-1:0] dvd, input logic [N-1:0] dsr,
                          output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
    if (dsr == 0) begin
      q = '1;
      r = dvd;
      z = 1'b1;
    end else begin
      q = N'(int'(dvd) / int'(dsr));
      r = N'(int'(dvd) % int'(dsr));
      z = 1'b0;
    end
  endtask

  // Pulse start for one edge, then count edges until done (bounded)
  task automatic applyStimulus(input logic [N-1:0] dvd, input logic [N-1:0] dsr,
                               output int lat, output bit sawBusy);
    @(negedge clk);
    dividend = dvd;
    divisor  = dsr;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat     = 0;
    sawBusy = 0;
    @(negedge clk);
    while (!done && lat < MaxWait) begin
      if (busy) sawBusy = 1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [N-1:0] dvd, input logic [N-1:0] dsr,
                             input bit checkLat, input int expLat);
    int lat;
    bit sawBusy;
    logic [N-1:0] q, r;
    logic z;
    refModel(dvd, dsr, q, r, z);
    applyStimulus(dvd, dsr, lat, sawBusy);
    if (checkLat) begin
      checkOutput({tag, " latency"}, lat, expLat);
      checkOutput({tag, " busy seen"}, sawBusy, (dsr != 0));
    end
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " quotient"}, quotient, q);
    checkOutput({tag, " remainder"}, remainder, r);
    checkOutput({tag, " dbz"}, div_by_zero, z);
    if (dsr != 0)
      checkOutput({tag, " invariant"},
                  ((int'(quotient) * int'(dsr) + int'(remainder)) == int'(dvd)) &&
                  (remainder < dsr), 1);
  endtask

  initial begin
    int lat;
    bit sawBusy;
    logic [N-1:0] rd, rs;

    vectors[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 4};
    vectors[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4};
    vectors[2] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 4};
    vectors[3] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 4};
    vectors[4] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4};
    vectors[5] = '{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 0};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset quotient", quotient, 0);
    checkOutput("reset remainder", remainder, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset dbz", div_by_zero, 0);
    reset = 1'b0;

    // Directed vector table
    foreach (vectors[i]) begin
      applyStimulus(vectors[i].dvd, vectors[i].dsr, lat, sawBusy);
      checkOutput($sformatf("vec%0d latency", i), lat, vectors[i].expLat);
      checkOutput($sformatf("vec%0d busy seen", i), sawBusy, !vectors[i].expDbz);
      checkOutput($sformatf("vec%0d done", i), done, 1);
      checkOutput($sformatf("vec%0d quotient", i), quotient, vectors[i].expQ);
      checkOutput($sformatf("vec%0d remainder", i), remainder, vectors[i].expR);
      checkOutput($sformatf("vec%0d dbz", i), div_by_zero, vectors[i].expDbz);
    end

    // Reset in the middle of a calculation aborts at once
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("abort busy before reset", busy, 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort quotient", quotient, 0);
    checkOutput("abort remainder", remainder, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    runAndCheck("post-reset 6/4", 4'd6, 4'd4, 1, 4);
    checkOutput("post-reset 6/4 q const", quotient, 1);
    checkOutput("post-reset 6/4 r const", remainder, 2);

    // start during CALC is ignored; start in DONE is accepted
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    dividend = 4'd8;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ignore busy before edge4", busy, 1);
    @(negedge clk);
    checkOutput("ignore done", done, 1);
    checkOutput("ignore quotient", quotient, 3);
    checkOutput("ignore remainder", remainder, 1);
    checkOutput("ignore dbz", div_by_zero, 0);
    runAndCheck("restart 8/2", 4'd8, 4'd2, 1, 4);
    checkOutput("restart 8/2 q const", quotient, 4);
    checkOutput("restart 8/2 r const", remainder, 0);

    // Exhaustive back-to-back sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        runAndCheck($sformatf("exh %0d/%0d", a, b), N'(a), N'(b), 1, (b == 0) ? 0 : N);

    // Random pairs, biased occasionally toward a zero divisor
    for (int k = 0; k < 40; k++) begin
      rd = N'($urandom_range(0, 15));
      rs = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, 15));
      runAndCheck($sformatf("rnd %0d/%0d", rd, rs), rd, rs, 1, (rs == 0) ? 0 : N);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
